// File: rtl/feeder_pkg.sv
// Shared constants for the row feeder: instruction codes and FSM state encoding.
package feeder_pkg;

  localparam int unsigned INST_W = 2;

  localparam logic [INST_W-1:0] INST_IDLE = 2'b00;
  localparam logic [INST_W-1:0] INST_LOAD = 2'b01;
  localparam logic [INST_W-1:0] INST_EXEC = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/feeder_fifo.sv
// Synchronous FIFO with first-word fall-through read and a registered entry count.
module feeder_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [width-1:0]         wr_data,
  output logic [width-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign full    = (count == CW'(depth));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/row_feeder.sv
// Queues instruction/data vectors and issues them diagonally skewed onto the mac_array west edge.
// Define FEEDER_OCC_EN to expose the FIFO occupancy count as an output.
module row_feeder
  import feeder_pkg::*;
#(
  parameter int unsigned bw    = 4,
  parameter int unsigned row   = 8,
  parameter int unsigned depth = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [row*bw-1:0]     in_data,
  input  logic [1:0]            in_inst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  go,
  input  logic                  flush,
  output logic [row*bw-1:0]     out_w,
  output logic [2*row-1:0]      inst_w,
  output logic                  busy,
  output logic                  done
`ifdef FEEDER_OCC_EN
  ,
  output logic [$clog2(depth):0] occupancy
`endif
);

  localparam int unsigned VW = row * bw;
  localparam int unsigned EW = VW + INST_W;
  localparam int unsigned CW = $clog2(depth) + 1;
  localparam int unsigned DW = $clog2(row) + 1;
  localparam int unsigned RW = bw + INST_W;

  state_t          state;
  logic [DW-1:0]   drain_cnt;
  logic [EW-1:0]   fifo_rd;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            push;
  logic            pop;
  logic [VW-1:0]   s0_data;
  logic [INST_W-1:0] s0_inst;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = (state != ST_IDLE) && !fifo_empty;

  feeder_fifo #(
    .width (EW),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data ({in_inst, in_data}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef FEEDER_OCC_EN
  assign occupancy = fifo_count;
`else
  logic unused_count;
  assign unused_count = ^fifo_count;
`endif

  // Skew stage 0: popped entry, or a bubble when nothing is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_data <= '0;
      s0_inst <= INST_IDLE;
    end else if (pop) begin
      {s0_inst, s0_data} <= fifo_rd;
    end else begin
      s0_data <= '0;
      s0_inst <= INST_IDLE;
    end
  end

  // Row r sees its slice of stage 0 delayed by r cycles.
  for (genvar r = 0; r < row; r++) begin : g_row
    if (r == 0) begin : g_direct
      assign out_w[0 +: bw]  = s0_data[0 +: bw];
      assign inst_w[0 +: 2]  = s0_inst;
    end else begin : g_dly
      logic [r-1:0][RW-1:0] dly;
      always_ff @(posedge clk) begin
        if (reset) begin
          dly <= '0;
        end else begin
          dly[0] <= {s0_inst, s0_data[r*bw +: bw]};
          for (int k = 1; k < r; k++) dly[k] <= dly[k-1];
        end
      end
      assign {inst_w[2*r +: 2], out_w[r*bw +: bw]} = dly[r-1];
    end
  end

  // Control FSM; done is raised for the cycle in which the drain counter reaches row-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          drain_cnt <= '0;
          done      <= 1'b0;
          if (go) begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          drain_cnt <= '0;
          if (flush) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (done) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            drain_cnt <= '0;
          end else if (!fifo_empty) begin
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
            done      <= (drain_cnt == DW'(row - 2));
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          drain_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_feeder.sv
// Randomized self-checking bench for row_feeder against a queue-based reference model.
module tb_row_feeder;
  import feeder_pkg::*;

  localparam int unsigned BW    = 4;
  localparam int unsigned ROW   = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned VW    = ROW * BW;
  localparam int unsigned W     = VW + 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [VW-1:0]     in_data;
  logic [1:0]        in_inst;
  logic              in_valid;
  logic              in_ready;
  logic              go;
  logic              flush;
  logic [VW-1:0]     out_w;
  logic [2*ROW-1:0]  inst_w;
  logic              busy;
  logic              done;
`ifdef FEEDER_OCC_EN
  logic [$clog2(DEPTH):0] occupancy;
`endif

  always #5 clk = ~clk;

  row_feeder #(
    .bw    (BW),
    .row   (ROW),
    .depth (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_inst  (in_inst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .go       (go),
    .flush    (flush),
    .out_w    (out_w),
    .inst_w   (inst_w),
    .busy     (busy),
    .done     (done)
`ifdef FEEDER_OCC_EN
    ,
    .occupancy (occupancy)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: queue of pending entries, history of what was issued, mode, drain count.
  logic [W-1:0] mq [$];
  logic [W-1:0] hist [ROW];
  int           mode;
  int           dcnt;
  bit           mdone;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int r = 0; r < int'(ROW); r++) v[r*BW +: BW] = BW'($urandom);
    return v;
  endfunction

  task automatic compare();
    logic [VW-1:0]    eo;
    logic [2*ROW-1:0] ei;
    for (int r = 0; r < int'(ROW); r++) begin
      eo[r*BW +: BW] = hist[r][r*BW +: BW];
      ei[2*r +: 2]   = hist[r][VW +: 2];
    end
    check("out_w", 64'(out_w), 64'(eo));
    check("inst_w", 64'(inst_w), 64'(ei));
    check("in_ready", 64'(in_ready), 64'(mq.size() < int'(DEPTH)));
    check("busy", 64'(busy), 64'(mode != 0));
    check("done", 64'(done), 64'(mdone));
`ifdef FEEDER_OCC_EN
    check("occupancy", 64'(occupancy), 64'(mq.size()));
`endif
  endtask

  task automatic model_step();
    logic [W-1:0] e;
    int occ;
    if (reset) begin
      mq.delete();
      for (int r = 0; r < int'(ROW); r++) hist[r] = '0;
      mode  = 0;
      dcnt  = 0;
      mdone = 0;
      return;
    end
    occ = mq.size();
    e   = '0;
    if (mode != 0 && occ > 0) e = mq.pop_front();
    if (in_valid && occ < int'(DEPTH)) mq.push_back({in_inst, in_data});
    for (int r = int'(ROW) - 1; r > 0; r--) hist[r] = hist[r-1];
    hist[0] = e;
    case (mode)
      0: begin
        mdone = 0;
        if (go) mode = 1;
      end
      1: if (flush) begin
        mode = 2;
        dcnt = 0;
      end
      default: begin
        if (mdone) begin
          mode  = 0;
          mdone = 0;
          dcnt  = 0;
        end else begin
          dcnt  = (occ > 0) ? 0 : dcnt + 1;
          mdone = (dcnt == int'(ROW) - 1);
        end
      end
    endcase
  endtask

  task automatic tick(input bit rs, input bit v, input bit g, input bit f, input logic [1:0] ins);
    @(negedge clk);
    compare();
    reset    = rs;
    in_valid = v;
    go       = g;
    flush    = f;
    in_inst  = ins;
    in_data  = rand_vec();
    model_step();
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0, INST_IDLE);
  endtask

  task automatic push(input int n, input logic [1:0] ins);
    repeat (n) tick(1'b0, 1'b1, 1'b0, 1'b0, ins);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    go       = 1'b0;
    flush    = 1'b0;
    in_inst  = INST_IDLE;
    in_data  = '0;
    model_step();
    repeat (2) @(posedge clk);

    // Three vectors, then go, then flush and drain.
    idle(2);
    push(1, INST_LOAD);
    push(1, INST_EXEC);
    push(1, INST_LOAD);
    idle(2);
    tick(1'b0, 1'b0, 1'b1, 1'b0, INST_IDLE);
    idle(12);
    tick(1'b0, 1'b0, 1'b0, 1'b1, INST_IDLE);
    idle(12);

    // Fill to capacity without go; the ninth push must be refused.
    push(9, INST_EXEC);
    idle(2);

    // Run until empty and keep issuing bubbles; go and flush together in IDLE is tested later.
    tick(1'b0, 1'b0, 1'b1, 1'b0, INST_IDLE);
    idle(18);
    tick(1'b0, 1'b0, 1'b0, 1'b1, INST_IDLE);
    idle(12);

    // Four load vectors, go, immediate flush, drain.
    push(4, INST_LOAD);
    tick(1'b0, 1'b0, 1'b1, 1'b1, INST_IDLE);
    tick(1'b0, 1'b0, 1'b0, 1'b1, INST_IDLE);
    idle(14);

    // Reset mid-run with five entries still queued, then restart cleanly.
    push(6, INST_EXEC);
    tick(1'b0, 1'b0, 1'b1, 1'b0, INST_IDLE);
    idle(1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, INST_IDLE);
    idle(3);
    push(2, INST_LOAD);
    tick(1'b0, 1'b0, 1'b1, 1'b0, INST_IDLE);
    idle(12);
    tick(1'b0, 1'b0, 1'b0, 1'b1, INST_IDLE);
    idle(12);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 199) == 0,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 14) == 0,
           2'($urandom_range(0, 2)));
    end

    @(negedge clk);
    compare();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/row_feeder.md
ROW_FEEDER -- requirements
Module: row_feeder

Interface
REQ-001 SHALL have parameter bw, default 4, activation/weight width per row.
REQ-002 SHALL have parameter row, default 8, number of mac_array rows fed (>=2).
REQ-003 SHALL have parameter depth, default 8, input FIFO entries (power of 2, >=2).
REQ-004 SHALL have clk  input  1  clock; all state on rising edge.
REQ-005 SHALL have reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have in_data  input  row*bw  one vector, row r at bits [r*bw +: bw].
REQ-007 SHALL have in_inst  input  2  instruction for the vector ({execute, kernel_load}).
REQ-008 SHALL have in_valid  input  1 and in_ready  output  1  push handshake.
REQ-009 SHALL have go  input  1  start issuing; flush  input  1  finish and drain.
REQ-010 SHALL have out_w  output  row*bw  skewed west data, row r at bits [r*bw +: bw].
REQ-011 SHALL have inst_w  output  2*row  skewed west instruction, row r at bits [2r +: 2].
REQ-012 SHALL have busy  output  1 (state != IDLE) and done  output  1  single-cycle drain-complete pulse.

Function
REQ-013 SHALL store {in_inst, in_data} in a depth-entry FIFO; push iff in_valid && in_ready.
REQ-014 SHALL drive in_ready = (occupancy < depth), independent of pop in the same cycle; pushes accepted in every state.
REQ-015 SHALL implement FSM IDLE, RUN, DRAIN; IDLE->RUN on go; RUN->DRAIN on flush; DRAIN->IDLE the cycle after done.
REQ-016 SHALL pop nothing in IDLE; in RUN/DRAIN pop one entry per cycle when FIFO non-empty, else issue a bubble (data 0, inst 2'b00).
REQ-017 SHALL register the popped entry or bubble into skew stage 0; row r output equals stage 0 delayed r cycles, so an entry popped in cycle t appears on row r in cycle t+1+r.
REQ-018 SHALL drive identical inst to all rows, skewed identically to data.
REQ-019 SHALL ignore go outside IDLE and flush outside RUN; go and flush together in IDLE: go taken, flush ignored.
REQ-020 SHALL, in DRAIN, hold a drain counter at 0 while FIFO non-empty, increment each empty cycle, and pulse done when counter == row-1 (same cycle as last entry's row row-1 output).
REQ-021 SHALL handle simultaneous push and pop at any occupancy with occupancy unchanged; pointers wrap modulo depth.

Reset
REQ-022 SHALL on reset, including mid-operation, empty the FIFO, clear all skew stages, enter IDLE, clear drain counter.
REQ-023 SHALL hold after reset: out_w=0, inst_w=0, in_ready=1, busy=0, done=0.

Configuration
REQ-024 SHALL, with FEEDER_OCC_EN defined, add output occupancy [$clog2(depth):0] giving registered FIFO entry count.
REQ-025 SHALL, without FEEDER_OCC_EN, omit the occupancy port and its logic; all other behaviour identical.

Structure
REQ-026 SHALL place the FSM state encoding and instruction constants INST_IDLE=2'b00, INST_LOAD=2'b01, INST_EXEC=2'b10 in shared package feeder_pkg.
REQ-027 SHALL implement the FIFO as sub-module feeder_fifo (parameters width, depth; push/pop/full/empty/count).

Verification
REQ-028 SHALL cover: reset, push 3 vectors, go -> vector k on row 0 at cycles 1..3 after go-edge pop, row 7 seven cycles later each.
REQ-029 SHALL cover: push 8 with no go -> in_ready=0 after 8th push; 9th in_valid not accepted; occupancy=8 (FEEDER_OCC_EN).
REQ-030 SHALL cover: RUN with FIFO empty -> out_w=0, inst_w=0 on all rows; busy=1.
REQ-031 SHALL cover: 4 INST_LOAD vectors then flush -> done pulses once, cycle of last vector's row-7 output; busy=0 next cycle.
REQ-032 SHALL cover: reset asserted mid-RUN with 5 entries queued -> next cycle all outputs 0, in_ready=1, state IDLE, no stale data after next go.
